// File: rtl/countdown_timer.sv
// countdown_timer: loads a BCD MM:SS start time on the rising edge of
// accum_done, then counts it down once per (strike-shortened) second.
// A defuse freezes the display; reaching 00:00 raises the sticky expired flag.
module countdown_timer #(
    parameter int TICK_DIV = 27000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        accum_done,
    input  logic [15:0] time_in,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  strikes,
    input  logic        defused,
    output logic [15:0] time_left,
    output logic        second_tick,
    output logic        running,
    output logic        expired,
    output logic        stopped
);

    localparam int PW = $clog2(TICK_DIV);

    // Terminal counts for 0, 1 and 2+ strikes (a second of 1, 3/4 and 1/2).
    localparam logic [PW-1:0] TERM0 = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] TERM1 = PW'((TICK_DIV >> 1) + (TICK_DIV >> 2) - 1);
    localparam logic [PW-1:0] TERM2 = PW'((TICK_DIV >> 1) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_RUNNING,
        S_PAUSED,
        S_EXPIRED,
        S_DEFUSED
    } state_t;

    state_t         state, state_d;
    logic [15:0]    time_d;
    logic [PW-1:0]  presc, presc_d;
    logic           tick_d;
    logic           accum_prev;
    logic           load_ev;
    logic [PW-1:0]  term;
    logic [15:0]    time_dec;

    // Clamp each digit to a legal BCD value; tens-of-seconds tops out at 5.
    function automatic logic [15:0] sanitize(input logic [15:0] t);
        logic [3:0] tm, m, ts, s;
        {tm, m, ts, s} = t;
        if (tm > 4'd9) tm = 4'd9;
        if (m  > 4'd9) m  = 4'd9;
        if (ts > 4'd5) ts = 4'd5;
        if (s  > 4'd9) s  = 4'd9;
        return {tm, m, ts, s};
    endfunction

    // One-second BCD decrement with the MM:SS borrow chain.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] tm, m, ts, s;
        {tm, m, ts, s} = t;
        if (s != 4'd0) begin
            s = s - 4'd1;
        end else begin
            s = 4'd9;
            if (ts != 4'd0) begin
                ts = ts - 4'd1;
            end else begin
                ts = 4'd5;
                if (m != 4'd0) begin
                    m = m - 4'd1;
                end else begin
                    m  = 4'd9;
                    tm = tm - 4'd1;
                end
            end
        end
        return {tm, m, ts, s};
    endfunction

    assign load_ev  = accum_done & ~accum_prev;
    assign time_dec = bcd_dec(time_left);

    // Select the terminal count for the current strike level (3 acts as 2).
    always_comb begin
        case (strikes)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            default: term = TERM2;
        endcase
    end

    // State, time and prescaler registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            time_left   <= 16'h0000;
            presc       <= '0;
            second_tick <= 1'b0;
            accum_prev  <= 1'b0;
        end else begin
            state       <= state_d;
            time_left   <= time_d;
            presc       <= presc_d;
            second_tick <= tick_d;
            accum_prev  <= accum_done;
        end
    end

    // Next-state logic; priority is defused > tick/expiry > pause > start/load.
    always_comb begin
        state_d = state;
        time_d  = time_left;
        presc_d = presc;
        tick_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_ev) begin
                    time_d  = sanitize(time_in);
                    state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start) begin
                    if (time_left == 16'h0000) begin
                        state_d = S_EXPIRED;
                    end else begin
                        state_d = S_RUNNING;
                        presc_d = '0;
                    end
                end else if (load_ev) begin
                    time_d = sanitize(time_in);
                end
            end
            S_RUNNING: begin
                if (defused) begin
                    state_d = S_DEFUSED;
                end else if (presc >= term) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    time_d  = time_dec;
                    if (time_dec == 16'h0000) state_d = S_EXPIRED;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else begin
                    presc_d = presc + 1'b1;
                end
            end
            S_PAUSED: begin
                if (defused) state_d = S_DEFUSED;
                else if (!pause) state_d = S_RUNNING;
            end
            default: ;
        endcase
    end

    // Status flags decoded from the registered state.
    always_comb begin
        running = (state == S_RUNNING);
        expired = (state == S_EXPIRED);
        stopped = (state == S_DEFUSED);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (TICK_DIV 4 and 8) share stimulus
// and are compared every cycle against a seconds-based reference model.
module tb_countdown_timer;

    localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_EXP = 4, M_DEF = 5;

    logic        clock;
    logic        reset;
    logic        accum_done;
    logic [15:0] time_in;
    logic        start;
    logic        pause;
    logic [1:0]  strikes;
    logic        defused;

    logic [15:0] dut_tl      [2];
    logic        dut_tick    [2];
    logic        dut_run     [2];
    logic        dut_exp     [2];
    logic        dut_stop    [2];

    int  m_mode [2];
    int  m_secs [2];
    int  m_cnt  [2];
    bit  m_prev [2];
    bit  m_tick [2];

    int  n_pass  = 0;
    int  n_total = 0;
    bit  chk_en  = 0;

    countdown_timer #(.TICK_DIV(4)) u_div4 (
        .clock(clock), .reset(reset), .accum_done(accum_done), .time_in(time_in),
        .start(start), .pause(pause), .strikes(strikes), .defused(defused),
        .time_left(dut_tl[0]), .second_tick(dut_tick[0]), .running(dut_run[0]),
        .expired(dut_exp[0]), .stopped(dut_stop[0])
    );

    countdown_timer #(.TICK_DIV(8)) u_div8 (
        .clock(clock), .reset(reset), .accum_done(accum_done), .time_in(time_in),
        .start(start), .pause(pause), .strikes(strikes), .defused(defused),
        .time_left(dut_tl[1]), .second_tick(dut_tick[1]), .running(dut_run[1]),
        .expired(dut_exp[1]), .stopped(dut_stop[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // ---- reference model: time kept as a plain count of seconds ----
    function automatic int to_secs(input logic [15:0] t);
        int tm, m, ts, s;
        tm = int'(t[15:12]); m = int'(t[11:8]); ts = int'(t[7:4]); s = int'(t[3:0]);
        if (tm > 9) tm = 9;
        if (m > 9)  m = 9;
        if (ts > 5) ts = 5;
        if (s > 9)  s = 9;
        return (tm * 10 + m) * 60 + ts * 10 + s;
    endfunction

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Cycles per second minus one, for a given instance and strike count.
    function automatic int period_m1(input int k, input int sk);
        int d;
        d = (k == 0) ? 4 : 8;
        if (sk >= 2) return d / 2 - 1;
        if (sk == 1) return d / 2 + d / 4 - 1;
        return d - 1;
    endfunction

    task automatic mstep(input int k);
        bit ld;
        if (reset) begin
            m_mode[k] = M_IDLE; m_secs[k] = 0; m_cnt[k] = 0; m_prev[k] = 0; m_tick[k] = 0;
        end else begin
            ld = accum_done && !m_prev[k];
            m_prev[k] = accum_done;
            m_tick[k] = 0;
            case (m_mode[k])
                M_IDLE: if (ld) begin m_secs[k] = to_secs(time_in); m_mode[k] = M_LOADED; end
                M_LOADED: begin
                    if (start) begin
                        if (m_secs[k] == 0) m_mode[k] = M_EXP;
                        else begin m_mode[k] = M_RUN; m_cnt[k] = 0; end
                    end else if (ld) m_secs[k] = to_secs(time_in);
                end
                M_RUN: begin
                    if (defused) m_mode[k] = M_DEF;
                    else if (m_cnt[k] >= period_m1(k, int'(strikes))) begin
                        m_cnt[k] = 0;
                        m_tick[k] = 1;
                        m_secs[k] = m_secs[k] - 1;
                        if (m_secs[k] == 0) m_mode[k] = M_EXP;
                    end else if (pause) m_mode[k] = M_PAUSE;
                    else m_cnt[k] = m_cnt[k] + 1;
                end
                M_PAUSE: begin
                    if (defused) m_mode[k] = M_DEF;
                    else if (!pause) m_mode[k] = M_RUN;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) mstep(k);
    end

    // Every cycle, all outputs of both instances against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("i%0d.time_left", k), 32'(dut_tl[k]), 32'(to_bcd(m_secs[k])));
                check($sformatf("i%0d.second_tick", k), 32'(dut_tick[k]), 32'(m_tick[k]));
                check($sformatf("i%0d.running", k), 32'(dut_run[k]), 32'(m_mode[k] == M_RUN));
                check($sformatf("i%0d.expired", k), 32'(dut_exp[k]), 32'(m_mode[k] == M_EXP));
                check($sformatf("i%0d.stopped", k), 32'(dut_stop[k]), 32'(m_mode[k] == M_DEF));
            end
        end
    end

    // ---- stimulus helpers (all driven on the falling edge) ----
    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1; accum_done = 0; start = 0; pause = 0; defused = 0; strikes = 0;
        cyc(2);
        reset = 0;
        cyc(1);
    endtask

    task automatic do_load(input logic [15:0] v);
        time_in = v; accum_done = 1;
        cyc(1);
        accum_done = 0;
        cyc(1);
    endtask

    task automatic pulse_start();
        start = 1;
        cyc(1);
        start = 0;
    endtask

    // Bounded wait until instance k is running with its prescaler at value c.
    task automatic wait_cnt(input int k, input int c, input string tag);
        bit hit;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_mode[k] == M_RUN && m_cnt[k] == c) hit = 1;
            else cyc(1);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        reset = 1; accum_done = 0; time_in = 0; start = 0; pause = 0; strikes = 0; defused = 0;
        cyc(2);
        reset = 0;
        chk_en = 1;
        check("reset_time", 32'(dut_tl[0]), 32'h0000);
        check("reset_run", 32'(dut_run[0]), 32'd0);

        // start in IDLE is ignored
        pulse_start();
        check("idle_start", 32'(dut_run[0]), 32'd0);

        // load and run: 0600 -> 0559 after 4 cycles -> 0558 after 8
        do_load(16'h0600);
        check("load_0600", 32'(dut_tl[0]), 32'h0600);
        pulse_start();
        check("start_run", 32'(dut_run[0]), 32'd1);
        cyc(3);
        check("pre_tick", 32'(dut_tl[0]), 32'h0600);
        cyc(1);
        check("tick1", 32'(dut_tl[0]), 32'h0559);
        check("tick1_pulse", 32'(dut_tick[0]), 32'd1);
        cyc(4);
        check("tick2", 32'(dut_tl[0]), 32'h0558);
        cyc(20);

        // borrow chain 1000 -> 0959 -> 0958
        do_reset();
        do_load(16'h1000);
        pulse_start();
        cyc(4);
        check("borrow", 32'(dut_tl[0]), 32'h0959);
        cyc(10);

        // expiry from 0001
        do_reset();
        do_load(16'h0001);
        pulse_start();
        cyc(4);
        check("expire_time", 32'(dut_tl[0]), 32'h0000);
        check("expire_flag", 32'(dut_exp[0]), 32'd1);
        check("expire_run", 32'(dut_run[0]), 32'd0);
        cyc(12);

        // strikes: 1, 2, 3 (acts as 2), then cut mid-count
        do_reset();
        do_load(16'h0100);
        pulse_start();
        strikes = 1; cyc(24);
        strikes = 2; cyc(16);
        strikes = 3; cyc(8);
        strikes = 0;
        wait_cnt(1, 5, "wait_presc5");
        strikes = 2;
        cyc(1);
        check("strike_cut", 32'(dut_tick[1]), 32'd1);
        strikes = 0;

        // pause mid-second for 10 cycles
        cyc(3);
        pause = 1; cyc(10);
        pause = 0; cyc(12);

        // defuse on a tick cycle
        wait_cnt(0, 3, "wait_tickcyc");
        defused = 1;
        cyc(1);
        defused = 0;
        check("defuse_stop", 32'(dut_stop[0]), 32'd1);
        check("defuse_notick", 32'(dut_tick[0]), 32'd0);
        cyc(12);

        // zero load then start: immediate expiry, no tick
        do_reset();
        do_load(16'h0000);
        pulse_start();
        check("zero_exp", 32'(dut_exp[0]), 32'd1);
        check("zero_notick", 32'(dut_tick[0]), 32'd0);

        // sanitising
        do_reset();
        do_load(16'hFAFC);
        check("sanitize", 32'(dut_tl[1]), 32'h9959);

        // accum_done held high: single load
        do_reset();
        time_in = 16'h0300; accum_done = 1;
        cyc(1);
        time_in = 16'h0500;
        cyc(5);
        check("held_load", 32'(dut_tl[0]), 32'h0300);
        accum_done = 0;
        cyc(1);

        // reset in RUNNING, reset in EXPIRED, then reload
        do_reset();
        do_load(16'h0002);
        pulse_start();
        cyc(3);
        do_reset();
        check("rst_run_time", 32'(dut_tl[0]), 32'h0000);
        check("rst_run_flag", 32'(dut_run[0]), 32'd0);
        do_load(16'h0001);
        pulse_start();
        cyc(6);
        do_reset();
        check("rst_exp_flag", 32'(dut_exp[0]), 32'd0);
        do_load(16'h0042);
        check("reload", 32'(dut_tl[0]), 32'h0042);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 39) == 0) accum_done = ~accum_done;
            if ($urandom_range(0, 1) == 0) time_in = 16'($urandom) & 16'h00F7;
            else time_in = 16'($urandom);
            start = (accum_done == 1'b0) && ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            if ($urandom_range(0, 49) == 0) strikes = 2'($urandom);
            defused = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        reset = 0; start = 0; defused = 0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
